// File: rtl/msk_rnd_pkg.sv
// msk_rnd_pkg: shared LFSR constants, feeder state encoding and step function
package msk_rnd_pkg;
    localparam int LFSR_W = 32;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h80200003;
    typedef enum logic [1:0] {SEED, WARM, RUN} state_t;
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return s[0] ? (s >> 1) ^ LFSR_TAPS : s >> 1;
    endfunction
endpackage

// File: rtl/msk_lfsr32.sv
// msk_lfsr32: one 32-bit Galois LFSR lane with parallel load
module msk_lfsr32
    import msk_rnd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= '0;
        else if (load) state <= load_val;
        else if (step) state <= lfsr_step(state);
    end
endmodule

// File: rtl/msk_rnd_feeder.sv
// msk_rnd_feeder: seeded LFSR bank supplying masking randomness over a valid/enable port
module msk_rnd_feeder
    import msk_rnd_pkg::*;
#(
    parameter int d        = 2,
    parameter int RND_W    = d,
    parameter int WARM     = 64,
    parameter int RESEED_N = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      seed_data,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic             reseed,
    output logic [RND_W-1:0] rnd,
    output logic             rnd_valid,
    input  logic             rnd_en,
    output logic             reseed_due
);
    localparam int LANES = (RND_W + LFSR_W - 1) / LFSR_W;
    localparam int IDX_W = LANES > 1 ? $clog2(LANES) : 1;
    localparam int WC_W  = WARM > 0 ? $clog2(WARM + 1) : 1;
    localparam int DC_W  = RESEED_N > 0 ? $clog2(RESEED_N + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LANES - 1);
    localparam logic [WC_W-1:0]  WARM_LAST = WC_W'(WARM > 0 ? WARM - 1 : 0);
    localparam logic [DC_W-1:0]  DLV_LAST  = DC_W'(RESEED_N > 0 ? RESEED_N - 1 : 0);

    state_t                 state, state_d;
    logic [IDX_W-1:0]       idx, idx_d;
    logic [WC_W-1:0]        wcnt, wcnt_d;
    logic [DC_W-1:0]        dcnt, dcnt_d;
    logic                   load_ok, step, last_dlv;
    logic [LFSR_W-1:0]      seed_val;
    logic [LANES*LFSR_W-1:0] lanes;
    logic                   unused_hi;

    assign seed_ready = state == SEED;
    assign rnd_valid  = state == RUN;
    assign load_ok    = seed_ready && seed_valid && !reseed;
    assign step       = !reseed && (state == msk_rnd_pkg::WARM || (rnd_valid && rnd_en));
    assign last_dlv   = RESEED_N > 0 && dcnt == DLV_LAST;
    assign reseed_due = !reseed && rnd_valid && rnd_en && last_dlv;
    // A zero seed would lock the LFSR, so it is replaced by 1
    assign seed_val   = seed_data == '0 ? LFSR_W'(1) : seed_data;
    assign rnd        = lanes[RND_W-1:0];
    assign unused_hi  = ^lanes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
            idx   <= '0;
            wcnt  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            wcnt  <= wcnt_d;
            dcnt  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        wcnt_d  = wcnt;
        dcnt_d  = dcnt;
        if (reseed) begin
            state_d = SEED;
            idx_d   = '0;
            wcnt_d  = '0;
            dcnt_d  = '0;
        end else begin
            case (state)
                SEED: if (seed_valid) begin
                    idx_d = idx == IDX_LAST ? '0 : idx + 1'b1;
                    if (idx == IDX_LAST) state_d = WARM > 0 ? msk_rnd_pkg::WARM : RUN;
                end
                msk_rnd_pkg::WARM: begin
                    wcnt_d = wcnt == WARM_LAST ? '0 : wcnt + 1'b1;
                    if (wcnt == WARM_LAST) state_d = RUN;
                end
                RUN: if (rnd_en) begin
                    dcnt_d = last_dlv ? '0 : (RESEED_N > 0 ? dcnt + 1'b1 : dcnt);
                    if (last_dlv) state_d = SEED;
                end
                default: state_d = SEED;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        msk_lfsr32 u_lfsr (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load_ok && idx == IDX_W'(i)),
            .load_val(seed_val),
            .step    (step),
            .state   (lanes[i*LFSR_W +: LFSR_W])
        );
    end
endmodule
